// File: rtl/data_memory_responder_pkg.sv
// rtl/data_memory_responder_pkg.sv - shared FSM encodings and defaults for the data-memory responder
package data_memory_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int MEM_DEPTH   = 1024;
  localparam int MEM_LATENCY = 4;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/data_memory_responder_latency_counter.sv
// rtl/data_memory_responder_latency_counter.sv - loadable down-counter flagging the last wait cycle
module latency_counter
  import data_memory_responder_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - multi-cycle word-addressed data memory with req/ack handshake
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH   = MEM_DEPTH,
  parameter int LATENCY = MEM_LATENCY,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ack_o,
  output logic              err_o,
  output logic              stall_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e              state_q, state_d;
  logic                we_q, bad_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                cnt_done, accept, commit;
  logic                in_bad, c_we, c_bad;
  logic [IDX_W-1:0]    in_idx, c_idx;
  logic [DATA_W-1:0]   c_wdata;

  // The error is resolved at acceptance so only the word index has to be held.
  assign in_bad = (addr_i[1:0] != 2'b00) ||
                  ({2'b00, addr_i[ADDR_W-1:2]} >= ADDR_W'(DEPTH));
  assign in_idx = addr_i[IDX_W+1:2];
  assign accept = (state_q == S_IDLE) && req_i;

  latency_counter u_latency_counter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (accept),
    .val_i  (CNT_W'(LATENCY - 1)),
    .done_o (cnt_done)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_i) state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt_done) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_o   = (state_q == S_RESP);
    stall_o = req_i & ~ack_o;
    err_o   = err_q;
    rdata_o = rdata_q;
  end

  // With single-cycle latency the commit edge is the accepting edge, so use live inputs.
  always_comb begin
    c_we    = (state_q == S_IDLE) ? we_i    : we_q;
    c_bad   = (state_q == S_IDLE) ? in_bad  : bad_q;
    c_idx   = (state_q == S_IDLE) ? in_idx  : idx_q;
    c_wdata = (state_q == S_IDLE) ? wdata_i : wdata_q;
    commit  = (state_q != S_RESP) && (state_d == S_RESP);

    rdata_d = rdata_q;
    if (commit && !c_we) begin
      rdata_d = c_bad ? '0 : mem_q[c_idx];
    end

    err_d = err_q;
    if (commit) begin
      err_d = c_bad;
    end else if (state_q == S_RESP) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      we_q    <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= we_i;
        bad_q   <= in_bad;
        idx_q   <= in_idx;
        wdata_q <= wdata_i;
      end
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately left out of reset; a reset abandons the commit via state_q.
  always_ff @(posedge clk_i) begin
    if (commit && c_we && !c_bad) begin
      mem_q[c_idx] <= c_wdata;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - self-checking bench for data_memory_responder
module tb_data_memory_responder;

  localparam int LAT_A = 4;
  localparam int DEP_A = 1024;

  logic        clk = 1'b0;
  logic        rst_a, req_a, we_a, ack_a, err_a, stall_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic        rst_b, req_b, we_b, ack_b, err_b, stall_b;
  logic [31:0] addr_b, wdata_b, rdata_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mdl [DEP_A];
  bit          known [DEP_A];
  logic [31:0] rd_last = 32'h0;
  bit          rd_known = 1'b1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl [9];

  always #5 clk = ~clk;

  data_memory_responder #(.DEPTH(DEP_A), .LATENCY(LAT_A), .ADDR_W(32), .DATA_W(32)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
    .wdata_i(wdata_a), .rdata_o(rdata_a), .ack_o(ack_a), .err_o(err_a), .stall_o(stall_a)
  );

  data_memory_responder #(.DEPTH(16), .LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
    .wdata_i(wdata_b), .rdata_o(rdata_b), .ack_o(ack_b), .err_o(err_b), .stall_o(stall_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: memory as a plain array, rdata as "last read result".
  task automatic model_apply(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             output logic exp_err, output bit exp_valid, output logic [31:0] exp_rd);
    int unsigned widx;
    widx    = addr / 4;
    exp_err = (addr % 4 != 0) || (widx >= DEP_A);
    if (!we) begin
      if (exp_err) begin
        rd_last = 32'h0; rd_known = 1'b1;
      end else begin
        rd_last = mdl[widx]; rd_known = known[widx];
      end
    end else if (!exp_err) begin
      mdl[widx] = wd; known[widx] = 1'b1;
    end
    exp_valid = rd_known;
    exp_rd    = rd_last;
  endtask

  // Entered and left just after a rising edge with the responder idle.
  task automatic run_a(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input bit drop, output logic err, output logic [31:0] rd);
    int lat, stalls;
    lat = -1; stalls = 0; err = 1'b0; rd = 32'h0;
    we_a = we; addr_a = addr; wdata_a = wd; req_a = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ack_a) begin
        lat = c; err = err_a; rd = rdata_a;
        break;
      end
      if (stall_a) stalls++;
      @(posedge clk); #1;
      if (drop && c == 0) begin
        req_a = 1'b0; we_a = ~we; addr_a = $urandom; wdata_a = $urandom;
      end
    end
    @(posedge clk); #1;
    req_a = 1'b0;
    chk("latency", lat, LAT_A);
    if (!drop) chk("stall cycles", stalls, LAT_A);
  endtask

  logic        g_err, e_err;
  logic [31:0] g_rd, e_rd, r_addr;
  bit          e_valid, spurious;
  int          ack1, ack2;

  initial begin
    tbl[0] = '{1'b1, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 32'h12,   32'h99999999, 1'b1, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF};
    tbl[4] = '{1'b0, 32'h1000, 32'h0,        1'b1, 32'h0};
    tbl[5] = '{1'b1, 32'hFFC,  32'hA5A55A5A, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 32'hFFC,  32'h0,        1'b0, 32'hA5A55A5A};
    tbl[7] = '{1'b0, 32'h2,    32'h0,        1'b1, 32'h0};
    tbl[8] = '{1'b1, 32'h1000, 32'h11111111, 1'b1, 32'h0};

    rst_a = 1'b0; req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    rst_b = 1'b0; req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);
    chk("reset ack", ack_a, 0);
    chk("reset err", err_a, 0);
    chk("reset rdata", rdata_a, 0);
    chk("reset stall", stall_a, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_a(tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b0, g_err, g_rd);
      model_apply(tbl[i].we, tbl[i].addr, tbl[i].wdata, e_err, e_valid, e_rd);
      chk($sformatf("vec%0d err", i), g_err, tbl[i].exp_err);
      chk($sformatf("vec%0d rdata", i), g_rd, tbl[i].exp_rd);
    end

    // Back-to-back reads with req held throughout.
    run_a(1'b1, 32'h0, 32'h01020304, 1'b0, g_err, g_rd);
    model_apply(1'b1, 32'h0, 32'h01020304, e_err, e_valid, e_rd);
    run_a(1'b1, 32'h4, 32'h0A0B0C0D, 1'b0, g_err, g_rd);
    model_apply(1'b1, 32'h4, 32'h0A0B0C0D, e_err, e_valid, e_rd);
    we_a = 1'b0; addr_a = 32'h0; req_a = 1'b1; ack1 = -1; ack2 = -1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (ack1 >= 0 && ack2 < 0 && c == ack1 + 1) begin
        chk("b2b single-cycle ack", ack_a, 0);
        chk("b2b idle stall", stall_a, 1);
      end
      if (ack_a) begin
        if (ack1 < 0) begin
          ack1 = c; chk("b2b rdata0", rdata_a, 32'h01020304); addr_a = 32'h4;
        end else if (ack2 < 0) begin
          ack2 = c; chk("b2b rdata1", rdata_a, 32'h0A0B0C0D); req_a = 1'b0;
        end else begin
          chk("b2b extra ack", 1, 0);
        end
      end
      @(posedge clk); #1;
    end
    chk("b2b first ack cycle", ack1, LAT_A);
    chk("b2b ack spacing", ack2 - ack1, LAT_A + 1);
    model_apply(1'b0, 32'h0, 32'h0, e_err, e_valid, e_rd);
    model_apply(1'b0, 32'h4, 32'h0, e_err, e_valid, e_rd);

    // Asynchronous reset landing mid-cycle while ack is high.
    we_a = 1'b0; addr_a = 32'h0; req_a = 1'b1; ack1 = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ack_a) begin ack1 = c; break; end
    end
    chk("async setup ack", ack1, LAT_A);
    #2 rst_a = 1'b0;
    #1;
    chk("async ack", ack_a, 0);
    chk("async rdata", rdata_a, 0);
    chk("async err", err_a, 0);
    chk("async stall", stall_a, 1);
    req_a = 1'b0;
    @(posedge clk); #1 rst_a = 1'b1;
    rd_last = 32'h0; rd_known = 1'b1;

    // Reset during an uncommitted write.
    run_a(1'b1, 32'h20, 32'hCAFEF00D, 1'b0, g_err, g_rd);
    model_apply(1'b1, 32'h20, 32'hCAFEF00D, e_err, e_valid, e_rd);
    we_a = 1'b1; addr_a = 32'h20; wdata_a = 32'h1234; req_a = 1'b1; spurious = 1'b0;
    repeat (3) begin @(negedge clk); spurious |= ack_a; end
    rst_a = 1'b0; req_a = 1'b0;
    repeat (3) begin @(negedge clk); spurious |= ack_a; end
    @(posedge clk); #1 rst_a = 1'b1;
    repeat (3) begin @(negedge clk); spurious |= ack_a; end
    chk("reset-write no ack", spurious, 0);
    rd_last = 32'h0; rd_known = 1'b1;
    @(posedge clk); #1;
    run_a(1'b0, 32'h20, 32'h0, 1'b0, g_err, g_rd);
    chk("reset-write old data", g_rd, 32'hCAFEF00D);
    model_apply(1'b0, 32'h20, 32'h0, e_err, e_valid, e_rd);

    // Randomized traffic against the array model.
    for (int i = 0; i < 60; i++) begin
      int unsigned kind;
      logic        rwe;
      logic [31:0] rwd;
      bit          rdrop;
      kind = $urandom_range(0, 9);
      if (kind == 0)      r_addr = $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
      else if (kind == 1) r_addr = (DEP_A + $urandom_range(0, 4000)) * 4;
      else                r_addr = $urandom_range(0, 15) * 4;
      rwe   = $urandom_range(0, 1);
      rwd   = $urandom;
      rdrop = ($urandom_range(0, 3) == 0);
      run_a(rwe, r_addr, rwd, rdrop, g_err, g_rd);
      model_apply(rwe, r_addr, rwd, e_err, e_valid, e_rd);
      chk($sformatf("rand%0d err @%h", i, r_addr), g_err, e_err);
      if (e_valid) chk($sformatf("rand%0d rdata @%h", i, r_addr), g_rd, e_rd);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Single-cycle latency build with req held continuously.
    we_b = 1'b1; addr_b = 32'h8; wdata_b = 32'h55; req_b = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("B ack c%0d", c), ack_b, (c % 2 == 1));
      chk($sformatf("B stall c%0d", c), stall_b, (c % 2 == 0));
      if (ack_b) begin
        if (c == 1) begin
          chk("B write err", err_b, 0);
          chk("B write rdata", rdata_b, 0);
        end else if (c <= 7) begin
          chk($sformatf("B read err c%0d", c), err_b, 0);
          chk($sformatf("B read rdata c%0d", c), rdata_b, 32'h55);
        end else begin
          chk($sformatf("B range err c%0d", c), err_b, 1);
          chk($sformatf("B range rdata c%0d", c), rdata_b, 0);
        end
        we_b = 1'b0;
        if (c == 7) addr_b = 32'h40;
      end
      @(posedge clk); #1;
    end
    req_b = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
